en_pulse_gen: RTL

Programmable enable-strobe generator that drives the `en` inputs of downstream gate-level enable flops and registers. It converts a start command into single-cycle enable pulses, one every `period+1` clocks. It emits either a fixed-length burst or a continuous train, and flags completion. It sits directly upstream of the enable-flop datapath, so it defines when that datapath captures new data and when it holds.

---
 rtl/en_pulse_gen_if.sv | 34 +++
 rtl/en_pulse_gen.sv | 124 ++++++++++++
 2 files changed

// File: rtl/en_pulse_gen_if.sv
// en_pulse_gen_if
// Command/strobe bundle between a controller and en_pulse_gen.
//   start  : level-sampled run command (controller -> generator)
//   stop   : abort a run without done (controller -> generator)
//   period : strobe spacing minus one, captured at start
//   burst  : strobe count, 0 = continuous, captured at start
//   en     : single-cycle enable strobe (generator -> datapath)
//   busy   : high while a run is in progress
//   done   : single-cycle pulse with the final strobe of a finite burst
// Modports: master = controller side, slave = generator side.
`timescale 1ns/1ps

interface en_pulse_gen_if #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 8
);
  logic             start;
  logic             stop;
  logic [DIV_W-1:0] period;
  logic [CNT_W-1:0] burst;
  logic             en;
  logic             busy;
  logic             done;

  modport master (
    output start, stop, period, burst,
    input  en, busy, done
  );

  modport slave (
    input  start, stop, period, burst,
    output en, busy, done
  );
endinterface

// File: rtl/en_pulse_gen.sv
// en_pulse_gen
// Programmable enable-strobe generator. A start command launches a run that
// emits a one-cycle en strobe every period+1 clocks, either for a fixed
// burst (done pulses with the last strobe) or continuously until stop.
// Ports:
//   clk : clock, all state changes on the rising edge
//   rst : synchronous active-high reset
//   bus : en_pulse_gen_if.slave (start, stop, period, burst in; en, busy, done out)
// Optional feature: define EN_PULSE_GEN_RETRIGGER_EN to let start during a
// run recapture period/burst and restart the timing; by default start is
// ignored while running.
`timescale 1ns/1ps

module en_pulse_gen #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  en_pulse_gen_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             cont_q, cont_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      per_q   <= '0;
      rem_q   <= '0;
      cont_q  <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      per_q   <= per_d;
      rem_q   <= rem_d;
      cont_q  <= cont_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic. en and done default low so that each is a single-cycle
  // pulse; stop takes precedence over start in both states.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    per_d   = per_q;
    rem_d   = rem_q;
    cont_d  = cont_q;
    en_d    = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          per_d   = bus.period;
          div_d   = bus.period;
          rem_d   = bus.burst;
          cont_d  = (bus.burst == '0);
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end

      RUN: begin
        if (bus.stop) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
`ifdef EN_PULSE_GEN_RETRIGGER_EN
        else if (bus.start) begin
          // Restart timing exactly as if launched from IDLE.
          per_d  = bus.period;
          div_d  = bus.period;
          rem_d  = bus.burst;
          cont_d = (bus.burst == '0);
        end
`endif
        else if (div_q != '0) begin
          div_d = div_q - DIV_W'(1);
        end else begin
          // Divider expired: strobe and reload; continuous runs never touch rem_q.
          en_d  = 1'b1;
          div_d = per_q;
          if (!cont_q) begin
            if (rem_q == CNT_W'(1)) begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = IDLE;
            end else begin
              rem_d = rem_q - CNT_W'(1);
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.en   = en_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule
